// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU run-control / trace monitor.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DUMP_SUM,
    ST_DUMP_TRACE,
    ST_DUMP_REGS,
    ST_DONE
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_LIMIT = 2'd1;
  localparam logic [1:0] CAUSE_PC    = 2'd2;
  localparam logic [1:0] CAUSE_SELF  = 2'd3;

  localparam logic [1:0] TAG_SUM   = 2'd0;
  localparam logic [1:0] TAG_TRACE = 2'd1;
  localparam logic [1:0] TAG_REG   = 2'd2;

  localparam int NUM_REGS = 32;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Bundle between the run monitor, the CPU (retire/run/debug-read) and the dump consumer.
interface cpu_run_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                start;
  logic                retire_valid;
  logic [ADDR_W-1:0]   retire_pc;
  logic [31:0]         retire_inst;
  logic                run_en;
  logic [4:0]          rf_raddr;
  logic [DATA_W-1:0]   rf_rdata;
  logic                dump_valid;
  logic                dump_ready;
  logic [1:0]          dump_tag;
  logic [ADDR_W+31:0]  dump_data;
  logic [1:0]          halt_cause;
  logic [15:0]         retire_cnt;
  logic                done;

  modport slave (
    input  start, retire_valid, retire_pc, retire_inst, rf_rdata, dump_ready,
    output run_en, rf_raddr, dump_valid, dump_tag, dump_data, halt_cause, retire_cnt, done
  );

  modport master (
    output start, retire_valid, retire_pc, retire_inst, rf_rdata, dump_ready,
    input  run_en, rf_raddr, dump_valid, dump_tag, dump_data, halt_cause, retire_cnt, done
  );
endinterface

// File: rtl/trace_ram.sv
// Circular trace storage: one synchronous write port, one asynchronous read port.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset; only entries written in the current run are ever read back.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control and trace monitor: gates the CPU, records retires, halts, then streams a dump.
module cpu_run_monitor
  import cpu_dbg_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                TRACE_DEPTH = 16,
  parameter int                CYCLE_LIMIT = 30,
  parameter bit                HALT_PC_EN  = 1'b0,
  parameter logic [ADDR_W-1:0] HALT_PC     = ADDR_W'(32'h0000_3000),
  parameter bit                SELFLOOP_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  cpu_run_monitor_if.slave bus
);
  localparam int PTR_W   = $clog2(TRACE_DEPTH);
  localparam int FILL_W  = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + 32;

  state_t               r_state, w_state_next;
  logic                 r_run_en, r_dump_valid, r_done;
  logic [1:0]           r_dump_tag, r_halt_cause;
  logic [ENTRY_W-1:0]   r_dump_data;
  logic [15:0]          r_retire_cnt;
  logic [ADDR_W-1:0]    r_prev_pc;
  logic [PTR_W-1:0]     r_wptr;
  logic [FILL_W-1:0]    r_fill, r_rd_cnt;
  logic [5:0]           r_reg_idx;

  logic                 w_start, w_retire, w_xfer, w_halt;
  logic                 w_hit_pc, w_hit_self, w_hit_lim;
  logic                 w_trace_left, w_regs_left;
  logic                 w_load, w_load_trace, w_load_reg, w_finish;
  logic [1:0]           w_cause, w_load_tag;
  logic [15:0]          w_cnt_inc;
  logic [PTR_W-1:0]     w_oldest, w_rd_addr;
  logic [ENTRY_W-1:0]   w_rd_data, w_sum_word, w_reg_word, w_load_data;

  assign w_start  = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_retire = bus.retire_valid && (r_state == ST_RUN);
  assign w_xfer   = r_dump_valid && bus.dump_ready;

  // Halt tests see the retire as already counted.
  assign w_cnt_inc  = (&r_retire_cnt) ? r_retire_cnt : r_retire_cnt + 16'd1;
  assign w_hit_pc   = HALT_PC_EN && (bus.retire_pc == HALT_PC);
  assign w_hit_self = SELFLOOP_EN && (r_retire_cnt != 16'd0) && (bus.retire_pc == r_prev_pc);
  assign w_hit_lim  = (CYCLE_LIMIT != 0) && (w_cnt_inc == 16'(CYCLE_LIMIT));
  assign w_cause    = w_hit_pc   ? CAUSE_PC   :
                      w_hit_self ? CAUSE_SELF :
                      w_hit_lim  ? CAUSE_LIMIT : CAUSE_NONE;
  assign w_halt     = w_retire && (w_hit_pc || w_hit_self || w_hit_lim);

  assign w_trace_left = (r_rd_cnt != r_fill);
  assign w_regs_left  = (r_reg_idx != 6'(NUM_REGS));
  assign w_oldest     = (r_fill == FILL_W'(TRACE_DEPTH)) ? r_wptr : '0;
  assign w_rd_addr    = w_oldest + r_rd_cnt[PTR_W-1:0];
  assign w_sum_word   = {ADDR_W'(w_cnt_inc), 30'd0, w_cause};
  assign w_reg_word   = {27'd0, r_reg_idx[4:0],
                         (r_reg_idx == 6'd0) ? {ADDR_W{1'b0}} : ADDR_W'(bus.rf_rdata)};

  trace_ram #(.DEPTH(TRACE_DEPTH), .WIDTH(ENTRY_W), .AW(PTR_W)) u_trace (
    .clk     (clk),
    .i_we    (w_retire),
    .i_waddr (r_wptr),
    .i_wdata ({bus.retire_pc, bus.retire_inst}),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // NOTE: clocked state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every comb output gets a default before the case, so no latch can be inferred.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE:           if (bus.start) w_state_next = ST_RUN;
      ST_RUN:                     if (w_halt) w_state_next = ST_DUMP_SUM;
      ST_DUMP_SUM, ST_DUMP_TRACE: if (w_xfer) w_state_next = w_trace_left ? ST_DUMP_TRACE : ST_DUMP_REGS;
      ST_DUMP_REGS:               if (w_xfer && !w_regs_left) w_state_next = ST_DONE;
      default:                    w_state_next = ST_IDLE;
    endcase
  end

  // The output register always holds the word of the current state; a transfer loads its successor.
  always_comb begin
    w_load_trace = 1'b0;
    w_load_reg   = 1'b0;
    w_finish     = 1'b0;
    w_load_tag   = TAG_SUM;
    w_load_data  = w_sum_word;
    case (r_state)
      ST_DUMP_SUM, ST_DUMP_TRACE: begin
        w_load_trace = w_xfer && w_trace_left;
        w_load_reg   = w_xfer && !w_trace_left;
      end
      ST_DUMP_REGS: begin
        w_load_reg = w_xfer && w_regs_left;
        w_finish   = w_xfer && !w_regs_left;
      end
      default: ;
    endcase
    if (w_load_trace) begin
      w_load_tag  = TAG_TRACE;
      w_load_data = w_rd_data;
    end else if (w_load_reg) begin
      w_load_tag  = TAG_REG;
      w_load_data = w_reg_word;
    end
  end

  assign w_load = w_halt || w_load_trace || w_load_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_en     <= 1'b0;
      r_dump_valid <= 1'b0;
      r_done       <= 1'b0;
      r_dump_tag   <= TAG_SUM;
      r_dump_data  <= '0;
      r_halt_cause <= CAUSE_NONE;
      r_retire_cnt <= '0;
      r_prev_pc    <= '0;
      r_wptr       <= '0;
      r_fill       <= '0;
      r_rd_cnt     <= '0;
      r_reg_idx    <= '0;
    end else begin
      if (w_start) begin
        r_run_en     <= 1'b1;
        r_done       <= 1'b0;
        r_halt_cause <= CAUSE_NONE;
        r_retire_cnt <= '0;
        r_wptr       <= '0;
        r_fill       <= '0;
        r_rd_cnt     <= '0;
        r_reg_idx    <= '0;
      end
      if (w_retire) begin
        r_wptr       <= r_wptr + PTR_W'(1);
        r_retire_cnt <= w_cnt_inc;
        r_prev_pc    <= bus.retire_pc;
        if (r_fill != FILL_W'(TRACE_DEPTH)) r_fill <= r_fill + FILL_W'(1);
        if (w_halt) begin
          r_run_en     <= 1'b0;
          r_halt_cause <= w_cause;
        end
      end
      if (w_load) begin
        r_dump_valid <= 1'b1;
        r_dump_tag   <= w_load_tag;
        r_dump_data  <= w_load_data;
      end else if (w_finish) begin
        r_dump_valid <= 1'b0;
        r_done       <= 1'b1;
      end
      if (w_load_trace) r_rd_cnt  <= r_rd_cnt + FILL_W'(1);
      if (w_load_reg)   r_reg_idx <= r_reg_idx + 6'd1;
    end
  end

  assign bus.run_en     = r_run_en;
  assign bus.rf_raddr   = r_reg_idx[4:0];
  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_tag   = r_dump_tag;
  assign bus.dump_data  = r_dump_data;
  assign bus.halt_cause = r_halt_cause;
  assign bus.retire_cnt = r_retire_cnt;
  assign bus.done       = r_done;
endmodule

// File: doc/cpu_run_monitor.md
# cpu_run_monitor

Synthesizable run-control and trace monitor for the single-cycle MIPS CPU. It gates CPU execution through a run enable and records the last retired PC/instruction pairs in a circular buffer. It halts the CPU on a configurable condition and then streams a summary word, the trace and a full register-file snapshot over a valid/ready port. It sits beside `CPU` in the simulation and FPGA top levels and replaces fixed-cycle-count stop logic with a reusable, parametrised block.

## Interface
- `ADDR_W`, 32, PC width
- `DATA_W`, 32, register data width
- `TRACE_DEPTH`, 16, trace entries; power of two, at least 2
- `CYCLE_LIMIT`, 30, retire count that forces a halt; 0 disables this condition
- `HALT_PC_EN`, 0, enables PC-match halt
- `HALT_PC`, 32'h0000_3000, PC that triggers the match halt
- `SELFLOOP_EN`, 1, enables self-loop halt
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a run from IDLE or DONE
- `retire_valid`  in  1  CPU committed `retire_pc`/`retire_inst` this cycle
- `retire_pc`  in  ADDR_W  PC of the committing instruction
- `retire_inst`  in  32  instruction word being committed
- `run_en`  out  1  CPU may advance; low means PC and all writes are frozen
- `rf_raddr`  out  5  register-file debug read address
- `rf_rdata`  in  DATA_W  combinational register read data
- `dump_valid`  out  1  `dump_data` is valid
- `dump_ready`  in  1  consumer accepts the word
- `dump_tag`  out  2  word type: 0 summary, 1 trace, 2 register
- `dump_data`  out  ADDR_W+32  word payload
- `halt_cause`  out  2  0 none, 1 limit, 2 PC match, 3 self-loop
- `retire_cnt`  out  16  instructions retired in the current run, saturating
- `done`  out  1  dump complete

## Operation
- States:
  - IDLE: the reset state.
  - RUN
  - DUMP_SUM
  - DUMP_TRACE
  - DUMP_REGS
  - DONE
- Transitions:
  - IDLE/DONE → RUN on `start`. This clears `retire_cnt`, `halt_cause`, the trace write pointer and the fill count.
  - `start` in any other state is ignored.
- RUN: each `retire_valid` does the following:
  - writes {`retire_pc`, `retire_inst`} into the trace at the write pointer;
  - increments the write pointer, wrapping modulo TRACE_DEPTH;
  - increments the fill count, saturating at TRACE_DEPTH;
  - increments `retire_cnt`;
  - latches `retire_pc` as the previous PC.
- Halt conditions, evaluated on a retire after its effect is counted:
  - PC match: `retire_pc`==HALT_PC.
  - Self-loop: `retire_pc` equals the previous PC, with at least one prior retire.
  - Limit: the new `retire_cnt`==CYCLE_LIMIT.
- Halt priority when several conditions hit: PC match > self-loop > limit. A halt sets `halt_cause` and moves to DUMP_SUM. The halting instruction is committed and traced.
- Retires outside RUN are ignored.
- DUMP_SUM: emits exactly one word, tag 0, data = {zero-extended `retire_cnt`, 30'b0, `halt_cause`}.
- DUMP_TRACE: emits fill-count words, tag 1, oldest first.
  - The oldest entry is the write pointer when the buffer has wrapped, else entry 0.
  - If the fill count is 0, this state is skipped.
- DUMP_REGS: emits 32 words, tag 2, data = {27'b0, index, `rf_rdata` zero-extended}.
  - Register 0 is forced to 0.
  - `rf_raddr` = current index.
- After register 31 is accepted: DONE, `done`=1.
- Handshake:
  - A word transfers when `dump_valid` & `dump_ready` are both high at a rising edge.
  - `dump_valid` stays high and `dump_data`/`dump_tag` stay stable until the transfer.
  - `dump_valid` never depends combinationally on `dump_ready`.

## Timing
- Reset values:
  - state IDLE;
  - `run_en`, `dump_valid`, `done` = 0;
  - `halt_cause` 0;
  - `retire_cnt` 0;
  - pointers and counts 0;
  - `rf_raddr` 0;
  - `dump_tag` 0;
  - `dump_data` 0.
  - Trace RAM contents need no reset.
- `run_en` is registered:
  - high from the cycle after `start`;
  - low from the cycle after the halting retire edge;
  - exactly CYCLE_LIMIT instructions retire on a limit halt.
- First dump word is valid the cycle after the halt edge; throughput is 1 word/cycle with `dump_ready` held high.
- `rf_raddr` is presented the cycle before its word is valid, so `rf_rdata` is captured into the output register.
- Reset asserted mid-run or mid-dump aborts immediately to IDLE with all outputs at reset values.

## Structure
- Shared package `cpu_dbg_pkg`:
  - state enum;
  - halt-cause constants;
  - dump-tag constants;
  - `NUM_REGS`=32.
- One sub-module: `trace_ram`, TRACE_DEPTH×(ADDR_W+32), one write port and one asynchronous read port, no reset.

## Test plan
- CYCLE_LIMIT=30, straight-line program at 32'h3000, `dump_ready`=1:
  - 30 retires then `run_en`=0;
  - summary cnt=30, cause=1;
  - 16 trace words with PCs 32'h3038…32'h3074;
  - 32 register words;
  - `done`=1.
- Program ending in `j` to itself at 32'h3010 (fifth instruction): halt after retire 6, cause=3, trace holds 6 entries starting at PC 32'h3000.
- HALT_PC_EN=1, HALT_PC=32'h3008, CYCLE_LIMIT=3, so both conditions hit on retire 3: cause=2 (priority).
- Random `dump_ready` toggling: no word lost or duplicated, and `dump_data` is stable while `dump_valid` is high and `dump_ready` is low.
- `rst` asserted during DUMP_TRACE: next cycle state IDLE, `dump_valid`=0, `run_en`=0; a subsequent `start` gives a clean run with `retire_cnt` from 0.
- `start` pulsed during RUN and during DUMP_REGS: no effect on count, trace or dump order.
